baud_ctrl: RTL
==============

# baud_ctrl

Configuration controller for the UART baud-rate generator. Holds a host-writable shadow divisor and enable bit, and applies a new divisor only when the transmitter and receiver are idle. During the switch it gates the generator's enable and pulses its reset, so the sample counter never runs against a smaller new divisor and wraps. It sits between the UART register front-end and the baud-rate generator.

## Interface
Parameters:
- DIV_W, 16, divisor width; matches generator divisor port
- RESET_DIV, 16'd26, divisor loaded at reset
- QUIET_CYC, 4, cycles the generator enable is held low before load (≥1)
- WAIT_MAX, 1023, max cycles spent waiting for TX/RX idle before forcing the update

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  register write strobe
- wr_addr  in  2  0=DLL (divisor[7:0]), 1=DLM (divisor[15:8]), 2=CTRL, 3=reserved (write ignored)
- wr_data  in  8  write data; CTRL bit0=enable, bit1=commit
- tx_busy  in  1  transmitter mid-frame
- rx_busy  in  1  receiver mid-frame
- baud_en  out  1  generator enable
- divisor  out  DIV_W  active divisor to generator
- gen_rst_n  out  1  generator reset, low for one cycle in LOAD
- cfg_busy  out  1  update in progress (state ≠ IDLE)
- cfg_done  out  1  one-cycle pulse when update completes
- cfg_err  out  1  one-cycle pulse on rejected write or commit
- cfg_forced  out  1  sticky; update forced by timeout; cleared by next accepted commit

## Operation
- Reset values: baud_en=0, divisor=RESET_DIV, shadow=RESET_DIV, en_bit=0, gen_rst_n=1, cfg_busy=0, cfg_done=0, cfg_err=0, cfg_forced=0, state=IDLE.
- IDLE:
  - DLL/DLM writes update the corresponding shadow byte.
  - CTRL write with commit=0 sets en_bit and drives baud_en=wr_data[0] on the next edge.
  - CTRL write with commit=1 and shadow≠0 latches en_bit, clears cfg_forced, clears the wait counter, and moves to WAIT_IDLE.
  - CTRL write with commit=1 and shadow==0 pulses cfg_err; state, baud_en and divisor are unchanged.
- WAIT_IDLE: baud_en is held at its current value.
  - tx_busy=0 and rx_busy=0 sampled → GATE.
  - Wait counter reaching WAIT_MAX → GATE and set cfg_forced.
- GATE: baud_en=0 for exactly QUIET_CYC cycles → LOAD.
- LOAD (one cycle): divisor<=shadow, gen_rst_n=0, baud_en=0 → IDLE.
- Return to IDLE: baud_en<=en_bit and cfg_done pulses on the same edge.
- Any wr_en while cfg_busy=1 is dropped, shadow is untouched, and cfg_err pulses.
- Shadow bytes written in IDLE are not visible on divisor until a commit completes.

## Timing
- All outputs are registered; no combinational input→output paths.
- Commit write sampled at edge N, peers idle:
  - WAIT_IDLE from N+1, GATE from N+2 (baud_en=0 from N+2).
  - LOAD at N+2+QUIET_CYC: divisor and gen_rst_n=0 take effect on this edge.
  - IDLE at N+3+QUIET_CYC: baud_en=en_bit, gen_rst_n=1, cfg_done=1 for one cycle.
- Busy peers: each cycle in WAIT_IDLE with either busy high adds one cycle. Forced exit occurs after WAIT_MAX cycles in WAIT_IDLE.
- Simultaneous busy deassert and timeout in the same cycle counts as a normal exit; cfg_forced stays 0.
- cfg_err and cfg_done never assert in the same cycle.
- rst_n low at any edge, including mid-GATE or LOAD, returns every register to its reset value on that edge. The update is abandoned and gen_rst_n=1.

## Structure
- Shared uart_define package holds register address constants (DLL/DLM/CTRL), CTRL bit positions, and the state encoding (IDLE, WAIT_IDLE, GATE, LOAD).
- Single module with no sub-module. The FSM, a QUIET_CYC down-counter and the WAIT_MAX counter all live in baud_ctrl. The wait counter width is $clog2(WAIT_MAX+1).

## Test plan
- Reset, then write DLL=0x0A, DLM=0x00, CTRL=0x03 with peers idle → divisor=0x000A at edge N+6, baud_en=1 and cfg_done pulse at N+7 (QUIET_CYC=4); baud_en low N+2..N+6; gen_rst_n low only at N+6.
- tx_busy=1 for 20 cycles after commit → GATE entered on the cycle after tx_busy falls; cfg_forced=0.
- rx_busy stuck high, WAIT_MAX=15 → update forced after 15 WAIT_IDLE cycles; cfg_forced=1 until the next commit is accepted.
- Commit with shadow=0x0000 → cfg_err pulse; divisor stays 26; cfg_busy stays 0.
- DLL write during GATE → cfg_err pulse; loaded divisor equals the pre-commit shadow.
- rst_n low during GATE → next edge: baud_en=0, divisor=26, state IDLE, no cfg_done.

Source files
------------

// File: rtl/uart_define_pkg.sv
// Shared UART definitions: register map, CTRL bits,
// and baud_ctrl state encoding.
package uart_define;

  localparam logic [1:0] ADDR_DLL  = 2'd0;
  localparam logic [1:0] ADDR_DLM  = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_COMMIT_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_GATE      = 2'd2,
    ST_LOAD      = 2'd3
  } state_e;

endpackage

// File: rtl/baud_ctrl.sv
// Baud generator config controller: shadows the divisor and
// swaps it in only once TX/RX are idle, gating the generator.
module baud_ctrl
  import uart_define::*;
#(
  parameter int              DIV_W     = 16,
  parameter logic [DIV_W-1:0] RESET_DIV = 16'd26,
  parameter int              QUIET_CYC = 4,
  parameter int              WAIT_MAX  = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             tx_busy,
  input  logic             rx_busy,
  output logic             baud_en,
  output logic [DIV_W-1:0] divisor,
  output logic             gen_rst_n,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             cfg_forced
);

  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam int QCW = $clog2(QUIET_CYC + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_MAX - 1);
  localparam logic [QCW-1:0] QUIET_LAST = QCW'(QUIET_CYC - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [QCW-1:0]   quiet_q, quiet_d;
  logic             en_bit_q, en_bit_d;
  logic             baud_en_q, baud_en_d;
  logic             gen_rst_n_q, gen_rst_n_d;
  logic             cfg_busy_q, cfg_busy_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_forced_q, cfg_forced_d;
  logic             err_pend_q, err_pend_d;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    divisor_d    = divisor_q;
    wait_cnt_d   = wait_cnt_q;
    quiet_d      = quiet_q;
    en_bit_d     = en_bit_q;
    baud_en_d    = baud_en_q;
    gen_rst_n_d  = 1'b1;
    cfg_done_d   = 1'b0;
    cfg_err_d    = err_pend_q;
    cfg_forced_d = cfg_forced_q;
    err_pend_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          unique case (wr_addr)
            ADDR_DLL: shadow_d[7:0] = wr_data;
            ADDR_DLM: shadow_d[DIV_W-1:8] = wr_data[DIV_W-9:0];
            ADDR_CTRL: begin
              if (!wr_data[CTRL_COMMIT_BIT]) begin
                en_bit_d  = wr_data[CTRL_EN_BIT];
                baud_en_d = wr_data[CTRL_EN_BIT];
              end else if (shadow_q == '0) begin
                cfg_err_d = 1'b1;
              end else begin
                en_bit_d     = wr_data[CTRL_EN_BIT];
                cfg_forced_d = 1'b0;
                wait_cnt_d   = '0;
                state_d      = ST_WAIT_IDLE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_IDLE: begin
        if (wr_en) cfg_err_d = 1'b1;
        // Idle peers win over a coincident timeout
        if (!tx_busy && !rx_busy) begin
          state_d   = ST_GATE;
          baud_en_d = 1'b0;
          quiet_d   = QUIET_LAST;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d      = ST_GATE;
          baud_en_d    = 1'b0;
          quiet_d      = QUIET_LAST;
          cfg_forced_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ST_GATE: begin
        if (wr_en) cfg_err_d = 1'b1;
        baud_en_d = 1'b0;
        if (quiet_q == '0) begin
          state_d     = ST_LOAD;
          divisor_d   = shadow_q;
          gen_rst_n_d = 1'b0;
        end else begin
          quiet_d = quiet_q - QCW'(1);
        end
      end
      ST_LOAD: begin
        // Defer the error one cycle so it never overlaps done
        if (wr_en) err_pend_d = 1'b1;
        state_d    = ST_IDLE;
        baud_en_d  = en_bit_q;
        cfg_done_d = 1'b1;
      end
    endcase

    cfg_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shadow_q     <= RESET_DIV;
      divisor_q    <= RESET_DIV;
      wait_cnt_q   <= '0;
      quiet_q      <= '0;
      en_bit_q     <= 1'b0;
      baud_en_q    <= 1'b0;
      gen_rst_n_q  <= 1'b1;
      cfg_busy_q   <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_forced_q <= 1'b0;
      err_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      divisor_q    <= divisor_d;
      wait_cnt_q   <= wait_cnt_d;
      quiet_q      <= quiet_d;
      en_bit_q     <= en_bit_d;
      baud_en_q    <= baud_en_d;
      gen_rst_n_q  <= gen_rst_n_d;
      cfg_busy_q   <= cfg_busy_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
      cfg_forced_q <= cfg_forced_d;
      err_pend_q   <= err_pend_d;
    end
  end

  assign baud_en    = baud_en_q;
  assign divisor    = divisor_q;
  assign gen_rst_n  = gen_rst_n_q;
  assign cfg_busy   = cfg_busy_q;
  assign cfg_done   = cfg_done_q;
  assign cfg_err    = cfg_err_q;
  assign cfg_forced = cfg_forced_q;

endmodule
